mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Parametrised data-memory interconnect between TOP_CORE's data port and N memory-mapped targets (slot 0 = RAM, slots 1..N_SLV-1 = peripherals such as GPIO). It decodes the core's byte address into a target slot and local word offset, and runs each access as a handshake with a per-slot ready. It adds wait-state support, a timeout watchdog, error reporting for misaligned or unmapped accesses, and a saturating error counter. It replaces the fixed RAM/GPIO decode used in the FPGA top level.

## Interface
Parameters:
- N_SLV, 4, number of target slots (≥2); slot 0 is RAM
- RAM_WORDS, 1024, words in slot 0; power of 2
- SLOT_WORDS, 16, words per peripheral slot; power of 2, ≤ RAM_WORDS
- TIMEOUT, 15, max ACCESS cycles without ready before a bus error; ≥1
- AW, $clog2(RAM_WORDS), local word-address width (derived)

Ports:
- CLOCK  in  1  system clock, rising edge
- RST_n  in  1  asynchronous, active-low reset
- dmem_we  in  1  core write request
- dmem_re  in  1  core read request
- dmem_addr  in  32  core byte address
- dmem_wdata  in  32  core write data
- dmem_rdata  out  32  registered read data, valid while dmem_ready=1
- dmem_ready  out  1  one-cycle completion pulse; core stalls until seen
- dmem_err  out  1  bus error, qualified by dmem_ready
- slv_sel  out  N_SLV  one-hot target select
- slv_we  out  1  write strobe to the selected slot
- slv_re  out  1  read strobe to the selected slot
- slv_addr  out  AW  local word offset in the slot
- slv_wdata  out  32  write data
- slv_rdata  in  N_SLV*32  slot read data; slot k occupies bits [32k+31:32k]
- slv_ready  in  N_SLV  per-slot completion
- err_count  out  16  saturating error counter

## Operation
- Word index W = dmem_addr[31:2].
  - Slot 0 covers W < RAM_WORDS.
  - Slot k≥1 covers W in [RAM_WORDS+(k-1)*SLOT_WORDS, RAM_WORDS+k*SLOT_WORDS).
  - Any W beyond that range is unmapped.
  - slv_addr = W−base(k), zero-extended to AW.
- Misaligned when dmem_addr[1:0]≠0; misaligned accesses are errors.
- Request = dmem_we|dmem_re. If both are high, the access is a write and the read is dropped.
- FSM has 4 states:
  - IDLE: no strobes. On a request:
    - mapped and aligned: latch slot, offset, wdata and direction, then go to ACCESS
    - otherwise: go to ERR
  - ACCESS: slv_sel, slv_we/slv_re, slv_addr and slv_wdata are driven from the latched values and held every cycle. The timeout counter increments each cycle.
    - slv_ready[slot] sampled high: capture slot read data (reads only; writes capture 0) and go to RESP with err=0.
    - Counter reaches TIMEOUT with ready still low: go to RESP with err=1 and rdata=0.
  - ERR: go to RESP with err=1 and rdata=0.
  - RESP: dmem_ready=1 for exactly one cycle, dmem_err as latched, then go to IDLE unconditionally.
- Core request lines are ignored outside IDLE. A request dropped mid-access does not abort the transaction.
- Targets must tolerate a write strobe held over several identical cycles.
- err_count increments by 1 on each entry to RESP with err=1 and saturates at 16'hFFFF.

## Timing
- Reset (async, RST_n=0) sets:
  - state=IDLE
  - dmem_rdata=0, dmem_ready=0, dmem_err=0
  - slv_sel=0, slv_we=0, slv_re=0, slv_addr=0, slv_wdata=0
  - err_count=0, timeout counter=0
- Reset asserted mid-access aborts it immediately with no ready pulse.
- All outputs are registered. There is no combinational path from dmem_* or slv_* inputs to outputs.
- Request sampled in IDLE at edge 0 gives ACCESS in cycle 1.
  - Slave ready in cycle 1: RESP in cycle 2. This is the minimum latency of 2 cycles.
  - Each wait-state cycle adds 1 cycle.
- Timeout: RESP in cycle TIMEOUT+1 after entering ACCESS.
- Error path (misaligned or unmapped): RESP in cycle 2.
- Maximum throughput is one access per 3 cycles (IDLE, ACCESS, RESP).
- slv_ready of non-selected slots is ignored.

## Test plan
- RAM read of addr 0x0000_0010 with slv_rdata slot0=0x1234_5678 and ready in the first ACCESS cycle -> slv_sel=0001, slv_addr=4, dmem_ready in cycle 2, dmem_rdata=0x1234_5678, dmem_err=0.
- Write 0x0000_00AB to 0x0000_1000 (W=1024, slot 1, offset 0), ready after 3 wait cycles -> slv_sel=0010, slv_we held for 4 cycles, ready pulse in cycle 5, err=0.
- Read of 0x0000_1002 (misaligned) -> no slave strobe, dmem_ready in cycle 2 with err=1, rdata=0, err_count=1.
- Read of 0x0000_10C0 (W=1072, unmapped for N_SLV=4) -> error response; on slot 3 with ready never asserted -> timeout after 15 ACCESS cycles, err=1, err_count increments.
- Simultaneous we=1, re=1 -> slv_we=1, slv_re=0. Request dropped in cycle 2 of ACCESS -> transaction still completes with ready.
- RST_n pulsed low mid-ACCESS -> all outputs 0 asynchronously, state IDLE. Force err_count to 0xFFFF and issue an error -> count stays 0xFFFF.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl_if
// Bundles the core-side data port and the target-side slot bus handled by
// mem_bus_ctrl.
//   Core side : dmem_we, dmem_re, dmem_addr, dmem_wdata  (requests)
//               dmem_rdata, dmem_ready, dmem_err         (responses)
//   Slot side : slv_sel, slv_we, slv_re, slv_addr, slv_wdata (strobes)
//               slv_rdata, slv_ready                     (slot replies)
// Modports:
//   slave  - the interconnect: accepts core requests, drives the slot strobes
//   master - the surroundings: the core issuing requests and the slots
//            answering them
// ---------------------------------------------------------------------------
interface mem_bus_ctrl_if #(
    parameter int N_SLV = 4,
    parameter int AW    = 10
);
    logic                   dmem_we;
    logic                   dmem_re;
    logic [31:0]            dmem_addr;
    logic [31:0]            dmem_wdata;
    logic [31:0]            dmem_rdata;
    logic                   dmem_ready;
    logic                   dmem_err;

    logic [N_SLV-1:0]       slv_sel;
    logic                   slv_we;
    logic                   slv_re;
    logic [AW-1:0]          slv_addr;
    logic [31:0]            slv_wdata;
    logic [N_SLV*32-1:0]    slv_rdata;
    logic [N_SLV-1:0]       slv_ready;

    modport slave (
        input  dmem_we, dmem_re, dmem_addr, dmem_wdata, slv_rdata, slv_ready,
        output dmem_rdata, dmem_ready, dmem_err,
               slv_sel, slv_we, slv_re, slv_addr, slv_wdata
    );

    modport master (
        output dmem_we, dmem_re, dmem_addr, dmem_wdata, slv_rdata, slv_ready,
        input  dmem_rdata, dmem_ready, dmem_err,
               slv_sel, slv_we, slv_re, slv_addr, slv_wdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
// Data-memory interconnect between the core's data port and N_SLV
// memory-mapped targets. Slot 0 is RAM (RAM_WORDS words), slots 1..N_SLV-1
// are peripherals of SLOT_WORDS words each, packed directly above the RAM.
// Each access runs IDLE -> ACCESS -> RESP (or IDLE -> ERR -> RESP for a
// misaligned or unmapped address). ACCESS waits for the selected slot's
// ready, bounded by a TIMEOUT-cycle watchdog. Every error response bumps a
// saturating 16-bit counter.
// Ports:
//   CLOCK      in   system clock, rising edge
//   RST_n      in   asynchronous active-low reset
//   bus        slave modport of mem_bus_ctrl_if (core port + slot bus)
//   err_count  out  saturating count of error responses
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_bus_ctrl #(
    parameter int N_SLV      = 4,
    parameter int RAM_WORDS  = 1024,
    parameter int SLOT_WORDS = 16,
    parameter int TIMEOUT    = 15,
    parameter int AW         = $clog2(RAM_WORDS)
) (
    input  logic                 CLOCK,
    input  logic                 RST_n,
    mem_bus_ctrl_if.slave        bus,
    output logic [15:0]          err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // The watchdog fires when the counter has already seen TIMEOUT-1 idle
    // cycles and the current one is idle too, i.e. after TIMEOUT cycles.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR,
        ST_RESP
    } state_t;

    state_t              state_reg;
    logic [TW-1:0]       tmo_reg;
    logic [N_SLV-1:0]    sel_reg;
    logic                we_reg;
    logic                re_reg;
    logic [AW-1:0]       addr_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         rdata_reg;
    logic                ready_reg;
    logic                err_reg;
    logic [15:0]         err_count_reg;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]         word_idx;
    logic [N_SLV-1:0]    hit;
    logic [AW-1:0]       slot_off [N_SLV];
    logic [AW-1:0]       dec_off;
    logic                mapped;
    logic                aligned;
    logic                req;

    assign word_idx = {2'b00, bus.dmem_addr[31:2]};
    assign aligned  = (bus.dmem_addr[1:0] == 2'b00);
    assign mapped   = |hit;
    assign req      = bus.dmem_we | bus.dmem_re;

    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_dec
            if (gi == 0) begin : g_ram
                assign hit[gi]      = (word_idx < 32'(RAM_WORDS));
                assign slot_off[gi] = word_idx[AW-1:0];
            end else begin : g_per
                localparam logic [31:0] BASE = 32'(RAM_WORDS + (gi - 1) * SLOT_WORDS);
                assign hit[gi] = (word_idx >= BASE) &&
                                 (word_idx < BASE + 32'(SLOT_WORDS));
                // Only the low AW bits of (W - base) can be non-zero inside
                // the slot, so the subtraction is done at AW bits.
                assign slot_off[gi] = word_idx[AW-1:0] - BASE[AW-1:0];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // One-hot muxes: offset of the hit slot, read data / ready of the
    // latched slot. Ready of non-selected slots is masked out here.
    // ------------------------------------------------------------------
    logic [31:0]         rd_mux;
    logic                sel_ready;

    assign sel_ready = |(bus.slv_ready & sel_reg);

    always_comb begin
        dec_off = '0;
        rd_mux  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (hit[i]) begin
                dec_off = dec_off | slot_off[i];
            end
            if (sel_reg[i]) begin
                rd_mux = rd_mux | bus.slv_rdata[i*32 +: 32];
            end
        end
    end

    logic [15:0] err_count_next;
    assign err_count_next = (err_count_reg == 16'hFFFF) ? err_count_reg
                                                         : err_count_reg + 16'd1;

    // ------------------------------------------------------------------
    // Access FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg     <= ST_IDLE;
            tmo_reg       <= '0;
            sel_reg       <= '0;
            we_reg        <= 1'b0;
            re_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            ready_reg     <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        if (mapped && aligned) begin
                            sel_reg   <= hit;
                            // A simultaneous write+read is treated as a write.
                            we_reg    <= bus.dmem_we;
                            re_reg    <= ~bus.dmem_we;
                            addr_reg  <= dec_off;
                            wdata_reg <= bus.dmem_wdata;
                            tmo_reg   <= '0;
                            state_reg <= ST_ACCESS;
                        end else begin
                            state_reg <= ST_ERR;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (sel_ready) begin
                        rdata_reg <= re_reg ? rd_mux : 32'd0;
                        err_reg   <= 1'b0;
                        ready_reg <= 1'b1;
                        sel_reg   <= '0;
                        we_reg    <= 1'b0;
                        re_reg    <= 1'b0;
                        state_reg <= ST_RESP;
                    end else if (tmo_reg == TMO_LAST) begin
                        rdata_reg     <= 32'd0;
                        err_reg       <= 1'b1;
                        ready_reg     <= 1'b1;
                        sel_reg       <= '0;
                        we_reg        <= 1'b0;
                        re_reg        <= 1'b0;
                        err_count_reg <= err_count_next;
                        state_reg     <= ST_RESP;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end

                ST_ERR: begin
                    rdata_reg     <= 32'd0;
                    err_reg       <= 1'b1;
                    ready_reg     <= 1'b1;
                    err_count_reg <= err_count_next;
                    state_reg     <= ST_RESP;
                end

                ST_RESP: begin
                    rdata_reg <= 32'd0;
                    err_reg   <= 1'b0;
                    ready_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dmem_rdata = rdata_reg;
    assign bus.dmem_ready = ready_reg;
    assign bus.dmem_err   = err_reg;
    assign bus.slv_sel    = sel_reg;
    assign bus.slv_we     = we_reg;
    assign bus.slv_re     = re_reg;
    assign bus.slv_addr   = addr_reg;
    assign bus.slv_wdata  = wdata_reg;
    assign err_count      = err_count_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Directed bench for mem_bus_ctrl. Each access pushes its expected response
// (read data, error flag, latency) into a scoreboard queue when it is driven;
// the entry is popped and compared when dmem_ready is seen. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_ctrl;

    localparam int N_SLV      = 4;
    localparam int RAM_WORDS  = 1024;
    localparam int SLOT_WORDS = 16;
    localparam int TIMEOUT    = 15;
    localparam int AW         = $clog2(RAM_WORDS);

    logic        clk;
    logic        rst_n;
    logic [15:0] err_count;

    mem_bus_ctrl_if #(.N_SLV(N_SLV), .AW(AW)) bus ();

    mem_bus_ctrl #(
        .N_SLV      (N_SLV),
        .RAM_WORDS  (RAM_WORDS),
        .SLOT_WORDS (SLOT_WORDS),
        .TIMEOUT    (TIMEOUT),
        .AW         (AW)
    ) dut (
        .CLOCK     (clk),
        .RST_n     (rst_n),
        .bus       (bus),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access from an idle cycle until the ready pulse.
    //   rdy_cyc  : first ACCESS cycle in which the selected slot is ready (0 = never)
    //   pre_rdy  : ready value driven on all slots from the start
    //   drop_cyc : cycle in which the core request is withdrawn (0 = hold)
    task automatic do_access(
        input logic             we,
        input logic             re,
        input logic [31:0]      addr,
        input logic [31:0]      wdata,
        input logic [N_SLV-1:0] exp_sel,
        input logic [AW-1:0]    exp_addr,
        input int               rdy_cyc,
        input logic [N_SLV-1:0] pre_rdy,
        input int               drop_cyc,
        input logic [31:0]      exp_rdata,
        input logic             exp_err,
        input int               exp_lat,
        input int               exp_strobes
    );
        exp_t e;
        exp_t got;
        int   cyc;
        int   strobes;
        logic seen;

        @(negedge clk);
        check("ready_single_cycle", 32'(bus.dmem_ready), 32'd0);

        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        exp_q.push_back(e);
        if (exp_err) begin
            exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        end

        bus.dmem_we    = we;
        bus.dmem_re    = re;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
        bus.slv_ready  = pre_rdy;

        cyc     = 0;
        strobes = 0;
        seen    = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("slv_sel", 32'(bus.slv_sel), 32'(exp_sel));
                check("slv_we", 32'(bus.slv_we), 32'(we & (exp_sel != '0)));
                check("slv_re", 32'(bus.slv_re), 32'(re & ~we & (exp_sel != '0)));
                if (exp_sel != '0) begin
                    check("slv_addr", 32'(bus.slv_addr), 32'(exp_addr));
                    if (we) begin
                        check("slv_wdata", bus.slv_wdata, wdata);
                    end
                end
            end
            if (bus.slv_we || bus.slv_re) begin
                strobes++;
            end
            if (cyc == drop_cyc) begin
                bus.dmem_we = 1'b0;
                bus.dmem_re = 1'b0;
            end
            if (bus.dmem_ready) begin
                seen          = 1'b1;
                bus.dmem_we   = 1'b0;
                bus.dmem_re   = 1'b0;
                bus.slv_ready = '0;
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    got = exp_q.pop_front();
                    check("dmem_rdata", bus.dmem_rdata, got.rdata);
                    check("dmem_err", 32'(bus.dmem_err), 32'(got.err));
                    check("latency", 32'(cyc), 32'(got.lat));
                end
                check("err_count", 32'(err_count), 32'(exp_cnt));
                n_txn++;
                $display("txn %0d: we=%0b re=%0b addr=%h rdata=%h err=%0b lat=%0d strobes=%0d err_count=%0d",
                         n_txn, we, re, addr, bus.dmem_rdata, bus.dmem_err, cyc, strobes, err_count);
            end else if (rdy_cyc > 0 && cyc >= rdy_cyc) begin
                bus.slv_ready = pre_rdy | exp_sel;
            end
        end

        if (!seen) begin
            check("response_seen", 32'(seen), 32'd1);
            exp_q.delete();
            bus.dmem_we   = 1'b0;
            bus.dmem_re   = 1'b0;
            bus.slv_ready = '0;
        end
        check("strobe_cycles", 32'(strobes), 32'(exp_strobes));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n          = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_re    = 1'b0;
        bus.dmem_addr  = 32'd0;
        bus.dmem_wdata = 32'd0;
        bus.slv_ready  = '0;
        bus.slv_rdata  = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};

        // Reset state
        #12;
        check("rst_dmem_ready", 32'(bus.dmem_ready), 32'd0);
        check("rst_dmem_err", 32'(bus.dmem_err), 32'd0);
        check("rst_dmem_rdata", bus.dmem_rdata, 32'd0);
        check("rst_slv_sel", 32'(bus.slv_sel), 32'd0);
        check("rst_slv_we_re", 32'({bus.slv_we, bus.slv_re}), 32'd0);
        check("rst_slv_addr", 32'(bus.slv_addr), 32'd0);
        check("rst_slv_wdata", bus.slv_wdata, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RAM read, ready in first ACCESS cycle
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'd0, 4'b0001, 10'd4, 1, 4'b0000, 0,
                  32'h1234_5678, 1'b0, 2, 1);
        // Slot 1 write, three wait states; writes return zero data
        do_access(1'b1, 1'b0, 32'h0000_1000, 32'h0000_00AB, 4'b0010, 10'd0, 4, 4'b0000, 0,
                  32'd0, 1'b0, 5, 4);
        // Misaligned read
        do_access(1'b0, 1'b1, 32'h0000_1002, 32'd0, 4'b0000, 10'd0, 0, 4'b0000, 0,
                  32'd0, 1'b1, 2, 0);
        // Unmapped read just past the last peripheral slot
        do_access(1'b0, 1'b1, 32'h0000_10C0, 32'd0, 4'b0000, 10'd0, 0, 4'b0000, 0,
                  32'd0, 1'b1, 2, 0);
        // Last word of slot 3, ready never comes: watchdog
        do_access(1'b0, 1'b1, 32'h0000_10BC, 32'd0, 4'b1000, 10'd15, 0, 4'b0000, 0,
                  32'd0, 1'b1, TIMEOUT + 1, TIMEOUT);
        // Slot 2 read, first word
        do_access(1'b0, 1'b1, 32'h0000_1040, 32'd0, 4'b0100, 10'd0, 1, 4'b0000, 0,
                  32'hCCCC_0002, 1'b0, 2, 1);
        // we and re together act as a write; request dropped in cycle 2
        do_access(1'b1, 1'b1, 32'h0000_1054, 32'hCAFE_F00D, 4'b0100, 10'd5, 3, 4'b0000, 2,
                  32'd0, 1'b0, 4, 3);
        // Top RAM word; other slots ready throughout must be ignored
        do_access(1'b0, 1'b1, 32'h0000_0FFC, 32'd0, 4'b0001, 10'd1023, 2, 4'b1110, 0,
                  32'h1234_5678, 1'b0, 3, 2);

        // Reset in the middle of an access
        @(negedge clk);
        bus.dmem_re   = 1'b1;
        bus.dmem_addr = 32'h0000_0020;
        bus.slv_ready = '0;
        repeat (3) @(negedge clk);
        check("mid_access_re", 32'(bus.slv_re), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_slv_sel", 32'(bus.slv_sel), 32'd0);
        check("async_rst_slv_re", 32'(bus.slv_re), 32'd0);
        check("async_rst_slv_addr", 32'(bus.slv_addr), 32'd0);
        check("async_rst_dmem_ready", 32'(bus.dmem_ready), 32'd0);
        check("async_rst_err_count", 32'(err_count), 32'd0);
        exp_cnt     = 16'd0;
        bus.dmem_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_ready", 32'(bus.dmem_ready), 32'd0);
            check("post_rst_no_sel", 32'(bus.slv_sel), 32'd0);
        end

        // Normal operation after the aborted access
        do_access(1'b0, 1'b1, 32'h0000_1000, 32'd0, 4'b0010, 10'd0, 1, 4'b0000, 0,
                  32'hBBBB_0001, 1'b0, 2, 1);

        // Error counter saturation
        @(negedge clk);
        force dut.err_count_reg = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_reg;
        exp_cnt = 16'hFFFE;
        check("preset_err_count", 32'(err_count), 32'(exp_cnt));
        do_access(1'b0, 1'b1, 32'h0000_0001, 32'd0, 4'b0000, 10'd0, 0, 4'b0000, 0,
                  32'd0, 1'b1, 2, 0);
        do_access(1'b1, 1'b0, 32'h0001_0000, 32'h1, 4'b0000, 10'd0, 0, 4'b0000, 0,
                  32'd0, 1'b1, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
